fetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue. It sits between the word-addressed memory and the CPU0 decode/execute state machine.
- Issues sequential instruction reads on the memory bus (m_en/m_rw/mar, data returned on dbus).
- Buffers each returned word together with its address.
- Presents instructions to the core on a valid/ready handshake.
- Flushes and restarts from a new PC on a jump redirect.

---
 rtl/cpu0_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu0_pkg.sv
// Shared CPU0 definitions: word geometry, opcode constants and the
// prefetch-queue entry layout used by the fetch stage.
package cpu0_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [7:0] LD  = 8'h00;
  localparam logic [7:0] ST  = 8'h01;
  localparam logic [7:0] ADD = 8'h13;
  localparam logic [7:0] JMP = 8'h26;

  typedef struct packed {
    logic [WORD_W-1:0] ipc;
    logic [WORD_W-1:0] ir;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
    return addr + WORD_W'(INSTR_BYTES);
  endfunction

  // Jump targets are word addresses; the byte-offset bits carry no meaning.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read bus plus the instruction valid/ready handshake toward decode.
interface fetch_unit_if;
  import cpu0_pkg::*;

  logic              m_en;
  logic              m_rw;
  logic [WORD_W-1:0] mar;
  logic [WORD_W-1:0] dbus;
  logic              ir_valid;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] ipc;
  logic              ir_ready;

  modport master (
    output m_en, m_rw, mar, ir_valid, ir, ipc,
    input  dbus, ir_ready
  );

  modport slave (
    input  m_en, m_rw, mar, ir_valid, ir, ipc,
    output dbus, ir_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue of {address, instruction} pairs; flush wins
// over push and pop in the same cycle.
module fetch_fifo
  import cpu0_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: the storage is reset too, so the head word reads as zero after reset instead of X.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      count_q <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= wr_ptr_q + PW'(1);
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// CPU0 instruction fetch: sequential word reads into a prefetch queue,
// handed to decode on valid/ready, flushed and restarted on redirect.
module fetch_unit
  import cpu0_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc,
  fetch_unit_if.master      bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              m_en_q, m_en_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] fpc_q, fpc_d;
  logic [WORD_W-1:0] target_pc;

  logic          push, pop, q_full, q_empty, room_after;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;

  assign push = m_en_q && !redirect;
  assign pop  = !q_empty && bus.ir_ready && !redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data ('{ipc: mar_q, ir: bus.dbus}),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // A new read may issue only if the queue will not be full after this edge.
  assign room_after = !((q_full && !pop) ||
                        ((q_count == CW'(DEPTH - 1)) && push && !pop));
  assign target_pc  = align_word(redirect_pc);

  always_comb begin
    m_en_d = 1'b0;
    mar_d  = mar_q;
    fpc_d  = fpc_q;
    if (redirect) begin
      if (fetch_en) begin
        m_en_d = 1'b1;
        mar_d  = target_pc;
        fpc_d  = next_word_addr(target_pc);
      end else begin
        fpc_d  = target_pc;
      end
    end else if (fetch_en && room_after) begin
      m_en_d = 1'b1;
      mar_d  = fpc_q;
      fpc_d  = next_word_addr(fpc_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_en_q <= 1'b0;
      mar_q  <= '0;
      fpc_q  <= RESET_PC;
    end else begin
      m_en_q <= m_en_d;
      mar_q  <= mar_d;
      fpc_q  <= fpc_d;
    end
  end

  assign bus.m_en     = m_en_q;
  assign bus.m_rw     = 1'b1;
  assign bus.mar      = mar_q;
  assign bus.ir_valid = !q_empty;
  assign bus.ir       = q_head.ir;
  assign bus.ipc      = q_head.ipc;
  assign pc           = fpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects,
// drain with fetch disabled, address wrap and asynchronous reset.
module tb_fetch_unit;
  import cpu0_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] mem [64];
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  // Combinational word-addressed memory.
  assign bus.dbus = mem[bus.mar[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h001F0018;
    mem[1]  = 32'h002F0010;
    mem[2]  = 32'h003F0014;
    mem[3]  = 32'h13221000;
    mem[4]  = 32'h13332000;
    mem[5]  = 32'h26FFFFF4;
    mem[63] = 32'hA5A50001;

    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.ir_ready = 1'b0;
    #2;
    check("rst_valid", 32'(bus.ir_valid), 32'd0);
    check("rst_m_en",  32'(bus.m_en),     32'd0);
    check("rst_m_rw",  32'(bus.m_rw),     32'd1);
    check("rst_mar",   bus.mar,           32'h0);
    check("rst_pc",    pc,                32'h0);
    check("rst_ir",    bus.ir,            32'h0);
    check("rst_ipc",   bus.ipc,           32'h0);

    // Streaming with the core always ready.
    fetch_en = 1'b1; bus.ir_ready = 1'b1;
    @(negedge clock); reset = 1'b0;
    tick();
    check("t1_e1_valid", 32'(bus.ir_valid), 32'd0);
    check("t1_e1_m_en",  32'(bus.m_en),     32'd1);
    check("t1_e1_mar",   bus.mar,           32'h0);
    tick();
    check("t1_e2_valid", 32'(bus.ir_valid), 32'd1);
    check("t1_e2_ipc",   bus.ipc,           32'h0);
    check("t1_e2_ir",    bus.ir,            32'h001F0018);
    tick();
    check("t1_e3_ipc", bus.ipc, 32'h4);
    check("t1_e3_ir",  bus.ir,  32'h002F0010);
    tick();
    check("t1_e4_ipc", bus.ipc, 32'h8);
    check("t1_e4_ir",  bus.ir,  32'h003F0014);
    tick();
    check("t1_e5_ipc", bus.ipc, 32'hC);
    check("t1_e5_ir",  bus.ir,  32'h13221000);
    check("t1_e5_pc",  pc,      32'h14);
    check("t1_e5_mar", bus.mar, 32'h10);

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    #1;
    check("t6_valid", 32'(bus.ir_valid), 32'd0);
    check("t6_m_en",  32'(bus.m_en),     32'd0);
    check("t6_pc",    pc,                32'h0);
    check("t6_mar",   bus.mar,           32'h0);
    #2 reset = 1'b0;
    tick();
    check("t6_e1_valid", 32'(bus.ir_valid), 32'd0);
    check("t6_e1_mar",   bus.mar,           32'h0);
    tick();
    check("t6_e2_ipc", bus.ipc, 32'h0);
    check("t6_e2_ir",  bus.ir,  32'h001F0018);

    // Core never ready: exactly DEPTH reads, then issue stops.
    bus.ir_ready = 1'b0; reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_m_en", 32'(bus.m_en), 32'd1);
      check("t2_mar",  bus.mar,       32'(k * 4));
    end
    tick();
    check("t2_stop_m_en", 32'(bus.m_en), 32'd0);
    check("t2_stop_pc",   pc,            32'h10);
    repeat (3) tick();
    check("t2_hold_m_en",  32'(bus.m_en),     32'd0);
    check("t2_hold_mar",   bus.mar,           32'hC);
    check("t2_hold_valid", 32'(bus.ir_valid), 32'd1);
    check("t2_hold_ir",    bus.ir,            32'h001F0018);
    check("t2_hold_ipc",   bus.ipc,           32'h0);

    // Redirect with a full queue and ready asserted.
    redirect = 1'b1; redirect_pc = 32'hC; bus.ir_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("t3_valid", 32'(bus.ir_valid), 32'd0);
    check("t3_mar",   bus.mar,           32'hC);
    check("t3_m_en",  32'(bus.m_en),     32'd1);
    check("t3_pc",    pc,                32'h10);
    tick();
    check("t3_first_ipc", bus.ipc, 32'hC);
    check("t3_first_ir",  bus.ir,  32'h13221000);

    // Redirect while the read of 0x14 is in the cycle; low target bits ignored.
    tick();
    check("t4_ipc", bus.ipc, 32'h10);
    check("t4_ir",  bus.ir,  32'h13332000);
    check("t4_mar", bus.mar, 32'h14);
    redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect = 1'b0;
    check("t4_valid", 32'(bus.ir_valid), 32'd0);
    check("t4_mar2",  bus.mar,           32'h4);
    check("t4_pc",    pc,                32'h8);
    tick();
    check("t4_first_ipc", bus.ipc, 32'h4);
    check("t4_first_ir",  bus.ir,  32'h002F0010);

    // Drain three queued entries with fetch disabled.
    bus.ir_ready = 1'b0;
    tick();
    fetch_en = 1'b0;
    tick();
    check("t5_m_en", 32'(bus.m_en), 32'd0);
    check("t5_pc",   pc,            32'h10);
    check("t5_ipc",  bus.ipc,       32'h4);
    bus.ir_ready = 1'b1;
    tick();
    check("t5_pop1_ipc", bus.ipc, 32'h8);
    tick();
    check("t5_pop2_ipc", bus.ipc, 32'hC);
    tick();
    check("t5_empty_valid", 32'(bus.ir_valid), 32'd0);
    check("t5_empty_m_en",  32'(bus.m_en),     32'd0);
    check("t5_empty_pc",    pc,                32'h10);
    tick();
    check("t5_idle_valid", 32'(bus.ir_valid), 32'd0);
    check("t5_idle_pc",    pc,                32'h10);

    // Redirect with fetch disabled only moves the fetch pointer.
    redirect = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect = 1'b0;
    check("rd_off_m_en", 32'(bus.m_en), 32'd0);
    check("rd_off_pc",   pc,            32'h14);
    fetch_en = 1'b1;
    tick();
    check("rd_on_mar", bus.mar, 32'h14);
    check("rd_on_pc",  pc,      32'h18);
    tick();
    check("rd_on_ipc", bus.ipc, 32'h14);
    check("rd_on_ir",  bus.ir,  32'h26FFFFF4);

    // Fetch pointer wraps past the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    check("wrap_mar",   bus.mar,           32'hFFFFFFFC);
    check("wrap_pc",    pc,                32'h0);
    check("wrap_valid", 32'(bus.ir_valid), 32'd0);
    tick();
    check("wrap_ipc",  bus.ipc, 32'hFFFFFFFC);
    check("wrap_ir",   bus.ir,  32'hA5A50001);
    check("wrap_mar2", bus.mar, 32'h0);
    check("wrap_pc2",  pc,      32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
